// File: rtl/demux_rr_dispatch.sv
// rtl/demux_rr_dispatch.sv - round-robin 1:4 demux dispatcher with a one-word holding register
// Lanes are served in rotating order, skipping disabled lanes; only the selected lane carries data.
module demux_rr_dispatch #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       EN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [3:0]       OUT_VALID,
  input  logic [3:0]       OUT_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       SEL,
  output logic             BUSY
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             en_any;
  logic             in_ready;
  logic             accept;
  logic             depart;
  logic [1:0]       base;

  // First enabled lane at or after start, wrapping 3 -> 0.
  function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] en);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    en_any   = |EN;
    depart   = (state_q == ST_FULL) && OUT_READY[tgt_q];
    in_ready = !RST && en_any && ((state_q == ST_EMPTY) || OUT_READY[tgt_q]);
    accept   = IN_VALID && in_ready;
    // When the held word leaves this cycle, the search restarts just past it.
    base     = depart ? (tgt_q + 2'd1) : ptr_q;

    state_d  = state_q;
    ptr_d    = ptr_q;
    tgt_d    = tgt_q;
    data_d   = data_q;

    if (depart) begin
      ptr_d   = tgt_q + 2'd1;
      state_d = ST_EMPTY;
    end
    if (accept) begin
      data_d  = IN_DATA;
      tgt_d   = pick(base, EN);
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 2'd0;
      tgt_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
    end
  end

  // Lane outputs depend on registered state only.
  always_comb begin
    OUT_VALID = (state_q == ST_FULL) ? (4'b0001 << tgt_q) : 4'b0000;
    A         = OUT_VALID[0] ? data_q : '0;
    B         = OUT_VALID[1] ? data_q : '0;
    C         = OUT_VALID[2] ? data_q : '0;
    D         = OUT_VALID[3] ? data_q : '0;
    SEL       = tgt_q;
    BUSY      = (state_q == ST_FULL);
    IN_READY  = in_ready;
  end

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// tb/tb_demux_rr_dispatch.sv - self-checking bench for demux_rr_dispatch
// Directed scenarios plus random traffic, all compared against a cycle-level reference model.
module tb_demux_rr_dispatch;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] EN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] IN_DATA;
  logic [3:0] OUT_VALID;
  logic [3:0] OUT_READY;
  logic [7:0] A, B, C, D;
  logic [1:0] SEL;
  logic       BUSY;

  demux_rr_dispatch #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .A(A), .B(B), .C(C), .D(D), .SEL(SEL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: is a word held, what it is, where it goes, where the next search starts.
  bit         m_full;
  logic [7:0] m_word;
  int         m_lane;
  int         m_ptr;
  int         dq_lane[$];
  logic [7:0] dq_data[$];

  function automatic int first_enabled(input int start, input logic [3:0] en);
    for (int k = 0; k < 4; k++)
      if (en[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  task automatic model_reset();
    m_full = 0; m_word = 8'h00; m_lane = 0; m_ptr = 0;
  endtask

  // Drive one cycle of inputs, compare every output to the model, then advance the model.
  task automatic step(input bit rst, input logic [3:0] en, input bit iv,
                      input logic [7:0] din, input logic [3:0] ordy);
    bit         exp_rdy, acc, dep;
    int         start;
    logic [7:0] got_lane [4];
    RST = rst; EN = en; IN_VALID = iv; IN_DATA = din; OUT_READY = ordy;
    #3;
    got_lane[0] = A; got_lane[1] = B; got_lane[2] = C; got_lane[3] = D;
    exp_rdy = !rst && (en != 4'h0) && (!m_full || ordy[m_lane]);
    check("in_ready", IN_READY, exp_rdy);
    check("out_valid", OUT_VALID, m_full ? (32'd1 << m_lane) : 32'd0);
    for (int l = 0; l < 4; l++)
      check($sformatf("lane_%0d", l), got_lane[l], (m_full && m_lane == l) ? m_word : 8'h00);
    check("sel", SEL, m_lane);
    check("busy", BUSY, m_full);
    if (!rst)
      for (int l = 0; l < 4; l++)
        if (OUT_VALID[l] && ordy[l]) begin
          dq_lane.push_back(l);
          dq_data.push_back(got_lane[l]);
        end
    if (rst) begin
      model_reset();
    end else begin
      acc = iv && exp_rdy;
      dep = m_full && ordy[m_lane];
      start = m_ptr;
      if (dep) begin
        m_ptr  = (m_lane + 1) % 4;
        start  = m_ptr;
        m_full = 0;
      end
      if (acc) begin
        m_word = din;
        m_lane = first_enabled(start, en);
        m_full = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_deliveries(input string tag, input int lanes[5], input logic [7:0] base);
    check({tag, "_count"}, dq_lane.size(), 5);
    for (int i = 0; i < 5 && i < dq_lane.size(); i++) begin
      check($sformatf("%s_lane%0d", tag, i), dq_lane[i], lanes[i]);
      check($sformatf("%s_data%0d", tag, i), dq_data[i], base + 8'(i));
    end
  endtask

  int exp_t1[5] = '{0, 1, 2, 3, 0};
  int exp_t2[5] = '{0, 2, 0, 2, 0};

  initial begin
    model_reset();
    RST = 1; EN = 4'h0; IN_VALID = 0; IN_DATA = 8'h00; OUT_READY = 4'h0;
    @(posedge CLK); #1;
    step(1, 4'hF, 1, 8'h00, 4'hF);
    check("rst_busy", BUSY, 0);
    check("rst_valid", OUT_VALID, 0);

    // Full-rate rotation A,B,C,D,A
    dq_lane.delete(); dq_data.delete();
    for (int i = 0; i < 5; i++) step(0, 4'hF, 1, 8'h10 + 8'(i), 4'hF);
    step(0, 4'hF, 0, 8'h00, 4'hF);
    check_deliveries("t1", exp_t1, 8'h10);

    // Only A and C enabled
    step(1, 4'hF, 0, 8'h00, 4'h0);
    dq_lane.delete(); dq_data.delete();
    for (int i = 0; i < 5; i++) step(0, 4'h5, 1, 8'h20 + 8'(i), 4'hF);
    step(0, 4'h5, 0, 8'h00, 4'hF);
    check_deliveries("t2", exp_t2, 8'h20);

    // Backpressure: 0x55 held on A for 4 cycles, next word goes to B
    step(1, 4'hF, 0, 8'h00, 4'h0);
    step(0, 4'hF, 1, 8'h55, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'hF, 1, 8'h66, 4'h0);
      check("t3_hold_a", A, 8'h55);
    end
    step(0, 4'hF, 1, 8'h66, 4'h1);
    check("t3_next_b", SEL, 1);
    check("t3_b_data", B, 8'h66);
    step(0, 4'hF, 0, 8'h00, 4'hF);

    // Enables removed while a word waits on C
    step(1, 4'hF, 0, 8'h00, 4'h0);
    step(0, 4'hF, 1, 8'h01, 4'hF);
    step(0, 4'hF, 1, 8'h02, 4'hF);
    step(0, 4'hF, 1, 8'h77, 4'hB);
    check("t4_sel_c", SEL, 2);
    step(0, 4'h0, 1, 8'h88, 4'h0);
    step(0, 4'h0, 1, 8'h88, 4'h0);
    check("t4_hold_c", C, 8'h77);
    step(0, 4'h0, 1, 8'h88, 4'h4);
    check("t4_busy", BUSY, 0);
    step(0, 4'h0, 1, 8'h88, 4'hF);

    // Reset while holding 0xAA on B
    step(1, 4'hF, 0, 8'h00, 4'h0);
    step(0, 4'hF, 1, 8'h01, 4'hF);
    step(0, 4'hF, 1, 8'hAA, 4'hF);
    check("t5_b_data", B, 8'hAA);
    step(0, 4'hF, 0, 8'h00, 4'h0);
    step(1, 4'hF, 1, 8'h00, 4'h0);
    check("t5_valid", OUT_VALID, 0);
    check("t5_b_zero", B, 0);
    check("t5_sel", SEL, 0);
    step(0, 4'hF, 1, 8'h3C, 4'h0);
    check("t5_next_a", OUT_VALID, 4'h1);
    step(0, 4'hF, 0, 8'h00, 4'hF);

    // Wrap-around from pointer 3 with only A,B enabled
    step(1, 4'hF, 0, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) step(0, 4'hF, 1, 8'h40 + 8'(i), 4'hF);
    step(0, 4'hF, 0, 8'h00, 4'hF);
    step(0, 4'h3, 1, 8'h5A, 4'h0);
    check("t6_wrap_sel", SEL, 0);
    check("t6_wrap_a", A, 8'h5A);
    step(0, 4'h3, 0, 8'h00, 4'hF);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
           1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
